// File: rtl/vga_timing_gen_prog.sv
// vga_timing_gen_prog
//   Runtime-programmable VGA/DVI timing generator. Free-running x/y counters
//   are decoded into sync, visible-area and line/frame strobes, then delayed
//   by PIPE_DELAY register stages so they line up with a pixel pipeline.
//   New timings are staged in a shadow set and only take effect at the end
//   of a frame, so a mode switch never produces a truncated line or frame.
//
// Ports
//   clk                      pixel clock
//   rst                      synchronous active-high reset
//   cfg_h_* / cfg_v_*        requested timing (res, front porch, sync, back porch)
//   cfg_hs_pol, cfg_vs_pol   requested sync polarity (1 = active-high pulse)
//   cfg_load                 strobe: capture all cfg_* inputs
//   cfg_pending              captured configuration waiting for the next wrap
//   cfg_err                  one-cycle pulse: last cfg_load was rejected
//   vga_hsync, vga_vsync     sync outputs
//   vga_x, vga_y             pixel coordinates
//   video_active             inside the visible area
//   line_start, frame_start  x == 0 / x == 0 and y == 0
//   frame_count              completed frames, wraps
module vga_timing_gen_prog #(
  parameter int          BITWIDTH   = 12,
  parameter int          PIPE_DELAY = 2,
  parameter int          FC_WIDTH   = 16,
  parameter int unsigned DEF_H_RES  = 640,
  parameter int unsigned DEF_H_FP   = 16,
  parameter int unsigned DEF_H_SYNC = 96,
  parameter int unsigned DEF_H_BP   = 48,
  parameter int unsigned DEF_V_RES  = 480,
  parameter int unsigned DEF_V_FP   = 10,
  parameter int unsigned DEF_V_SYNC = 2,
  parameter int unsigned DEF_V_BP   = 33,
  parameter bit          DEF_HS_POL = 1'b0,
  parameter bit          DEF_VS_POL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] cfg_h_res,
  input  logic [BITWIDTH-1:0] cfg_h_fp,
  input  logic [BITWIDTH-1:0] cfg_h_sync,
  input  logic [BITWIDTH-1:0] cfg_h_bp,
  input  logic [BITWIDTH-1:0] cfg_v_res,
  input  logic [BITWIDTH-1:0] cfg_v_fp,
  input  logic [BITWIDTH-1:0] cfg_v_sync,
  input  logic [BITWIDTH-1:0] cfg_v_bp,
  input  logic                cfg_hs_pol,
  input  logic                cfg_vs_pol,
  input  logic                cfg_load,
  output logic                cfg_pending,
  output logic                cfg_err,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic [BITWIDTH-1:0] vga_x,
  output logic [BITWIDTH-1:0] vga_y,
  output logic                video_active,
  output logic                line_start,
  output logic                frame_start,
  output logic [FC_WIDTH-1:0] frame_count
);

  localparam int SW = BITWIDTH + 1;  // timing sums
  localparam int VW = BITWIDTH + 2;  // validation sums: four full-scale terms cannot overflow
  localparam logic [VW-1:0] TOTAL_LIMIT = VW'(1) << BITWIDTH;

  typedef struct packed {
    logic [BITWIDTH-1:0] h_res, h_fp, h_sync, h_bp;
    logic [BITWIDTH-1:0] v_res, v_fp, v_sync, v_bp;
    logic                hs_pol, vs_pol;
  } timing_t;

  typedef struct packed {
    logic                hsync, vsync, active, line_start, frame_start;
    logic [BITWIDTH-1:0] x, y;
  } tout_t;

  localparam timing_t DEF_SET = '{
    h_res: BITWIDTH'(DEF_H_RES), h_fp: BITWIDTH'(DEF_H_FP),
    h_sync: BITWIDTH'(DEF_H_SYNC), h_bp: BITWIDTH'(DEF_H_BP),
    v_res: BITWIDTH'(DEF_V_RES), v_fp: BITWIDTH'(DEF_V_FP),
    v_sync: BITWIDTH'(DEF_V_SYNC), v_bp: BITWIDTH'(DEF_V_BP),
    hs_pol: DEF_HS_POL, vs_pol: DEF_VS_POL};

  // Idle value of every delay stage: blank, syncs at their inactive level.
  localparam tout_t IDLE = '{hsync: ~DEF_HS_POL, vsync: ~DEF_VS_POL, active: 1'b0,
                             line_start: 1'b0, frame_start: 1'b0, x: '0, y: '0};

  timing_t act_q, act_d, shadow_q, shadow_d, cfg_in;
  logic [BITWIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                pending_q, pending_d, err_q;
  logic [FC_WIDTH-1:0] fc_q;

  // Active-set derived timing points.
  logic [SW-1:0] h_ss, h_se, h_max, v_ss, v_se, v_max;
  assign h_ss  = SW'(act_q.h_res) + SW'(act_q.h_fp);
  assign h_se  = h_ss + SW'(act_q.h_sync);
  assign h_max = h_se + SW'(act_q.h_bp);
  assign v_ss  = SW'(act_q.v_res) + SW'(act_q.v_fp);
  assign v_se  = v_ss + SW'(act_q.v_sync);
  assign v_max = v_se + SW'(act_q.v_bp);

  logic x_end, y_end, wrap;
  assign x_end = ({1'b0, x_q} == h_max - SW'(1));
  assign y_end = ({1'b0, y_q} == v_max - SW'(1));
  assign wrap  = x_end && y_end;

  // Request validation.
  assign cfg_in = '{h_res: cfg_h_res, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
                    v_res: cfg_v_res, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
                    hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};

  logic [VW-1:0] cfg_h_tot, cfg_v_tot;
  logic          cfg_valid, load_ok;
  assign cfg_h_tot = VW'(cfg_h_res) + VW'(cfg_h_fp) + VW'(cfg_h_sync) + VW'(cfg_h_bp);
  assign cfg_v_tot = VW'(cfg_v_res) + VW'(cfg_v_fp) + VW'(cfg_v_sync) + VW'(cfg_v_bp);
  assign cfg_valid = (cfg_h_res != '0) && (cfg_h_sync != '0) &&
                     (cfg_v_res != '0) && (cfg_v_sync != '0) &&
                     (cfg_h_tot <= TOTAL_LIMIT) && (cfg_v_tot <= TOTAL_LIMIT);
  assign load_ok   = cfg_load && cfg_valid;

  always_comb begin
    x_d       = x_q + BITWIDTH'(1);
    y_d       = y_q;
    act_d     = act_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (x_end) begin
      x_d = '0;
      y_d = y_end ? '0 : y_q + BITWIDTH'(1);
    end
    // The shadow being applied is the one held before this cycle, so a load
    // landing on the wrap itself is kept pending for the following wrap.
    if (wrap && pending_q) begin
      act_d = shadow_q;
    end
    if (load_ok) begin
      shadow_d  = cfg_in;
      pending_d = 1'b1;
    end else if (wrap) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      act_q     <= DEF_SET;
      shadow_q  <= DEF_SET;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      fc_q      <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      act_q     <= act_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= cfg_load && !cfg_valid;
      fc_q      <= wrap ? fc_q + FC_WIDTH'(1) : fc_q;
    end
  end

  // Stage-0 decode of the counters.
  logic  in_hpulse, in_vpulse;
  tout_t stage0, out_w;
  assign in_hpulse = ({1'b0, x_q} >= h_ss) && ({1'b0, x_q} < h_se);
  assign in_vpulse = ({1'b0, y_q} >= v_ss) && ({1'b0, y_q} < v_se);

  always_comb begin
    stage0.hsync       = act_q.hs_pol ? in_hpulse : !in_hpulse;
    stage0.vsync       = act_q.vs_pol ? in_vpulse : !in_vpulse;
    stage0.active      = (x_q < act_q.h_res) && (y_q < act_q.v_res);
    stage0.line_start  = (x_q == '0);
    stage0.frame_start = (x_q == '0) && (y_q == '0);
    stage0.x           = x_q;
    stage0.y           = y_q;
  end

  // All timing outputs travel as one bundle so they stay mutually aligned.
  generate
    if (PIPE_DELAY == 0) begin : g_nopipe
      assign out_w = stage0;
    end else begin : g_pipe
      tout_t pipe_q [PIPE_DELAY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= IDLE;
        end else begin
          pipe_q[0] <= stage0;
          for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign out_w = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  assign vga_hsync    = out_w.hsync;
  assign vga_vsync    = out_w.vsync;
  assign video_active = out_w.active;
  assign line_start   = out_w.line_start;
  assign frame_start  = out_w.frame_start;
  assign vga_x        = out_w.x;
  assign vga_y        = out_w.y;
  assign cfg_pending  = pending_q;
  assign cfg_err      = err_q;
  assign frame_count  = fc_q;

endmodule

// File: doc/vga_timing_gen_prog.md
Name: vga_timing_gen_prog

Overview:
- Runtime-programmable VGA/DVI timing generator, the successor to the fixed-parameter timing controller.
- Produces the pixel x/y counters, hsync/vsync, video_active, and line/frame strobes for the pixel pipeline and scan-out.
- Adds synchronous reset, frame-boundary-safe mode switching through shadow registers, a configurable output delay to match pixel-pipeline latency, and a frame counter.

Parameters:
- BITWIDTH, 12, width of all timing fields and of the x/y counters.
- PIPE_DELAY, 2, register stages applied to every timing output (0 = combinational decode of the counters).
- FC_WIDTH, 16, width of frame_count.
- DEF_H_RES / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 640 / 16 / 96 / 48, horizontal timing applied at reset.
- DEF_V_RES / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 480 / 10 / 2 / 33, vertical timing applied at reset.
- DEF_HS_POL / DEF_VS_POL, 0 / 0, sync polarity applied at reset (0 = active-low pulse, 1 = active-high pulse).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  BITWIDTH each  requested horizontal timing.
- cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  BITWIDTH each  requested vertical timing.
- cfg_hs_pol, cfg_vs_pol  in  1 each  requested sync polarities.
- cfg_load  in  1  one-cycle strobe that captures all cfg_* inputs.
- cfg_pending  out  1  captured configuration not yet applied.
- cfg_err  out  1  one-cycle pulse when a load is rejected.
- vga_hsync, vga_vsync  out  1 each  sync outputs.
- vga_x, vga_y  out  BITWIDTH each  pixel coordinates.
- video_active  out  1  inside the visible area.
- line_start  out  1  high while x == 0.
- frame_start  out  1  high while x == 0 and y == 0.
- frame_count  out  FC_WIDTH  number of completed frames, wraps.

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high.
- Active timing set: H_MAX = h_res + h_fp + h_sync + h_bp; H_SYNC_START = h_res + h_fp; H_SYNC_STOP = H_SYNC_START + h_sync. Vertical set is identical in form.
- All sums are computed BITWIDTH+1 wide.
- Counters:
  - x increments each clock.
  - At x == H_MAX-1: x goes to 0 and y increments.
  - At y == V_MAX-1 on that same cycle, y goes to 0.
  - This end-of-frame cycle is the "wrap".
- Stage-0 decode from the counters:
  - hsync = hs_pol ? in_hpulse : !in_hpulse, where in_hpulse = H_SYNC_START <= x < H_SYNC_STOP. vsync is the same form.
  - active = (x < h_res) && (y < v_res).
  - line_start = (x == 0); frame_start = (x == 0) && (y == 0).
- Output delay:
  - hsync, vsync, active, x, y, line_start and frame_start pass together through PIPE_DELAY register stages, so they stay mutually aligned.
  - With PIPE_DELAY = 0 the outputs are the stage-0 decode.
- Reset:
  - Counters go to 0; the active set loads the DEF_* values; cfg_pending = 0, cfg_err = 0, frame_count = 0.
  - All delay stages load their idle values: x = 0, y = 0, active = 0, line_start = 0, frame_start = 0, and hsync/vsync at their inactive level (1 for pol 0).
  - After reset deasserts, stage-0 outputs show x = 0, y = 0 on the first cycle.
  - Reset mid-frame or mid-pending discards the pending configuration.
- Configuration load:
  - cfg_load captures all cfg_* inputs into shadow registers and sets cfg_pending on the next cycle.
  - A repeated cfg_load while pending overwrites the shadow; the last load wins.
  - On a wrap cycle with cfg_pending already set, the shadow is copied to the active set and cfg_pending clears. The counters wrap to 0 as normal, and the new timing governs from x = 0, y = 0.
  - A cfg_load that coincides with a wrap is captured but is applied at the following wrap.
- Validation:
  - A load is rejected if any of h_res, h_sync, v_res, v_sync is 0, or if H_MAX or V_MAX exceeds 2^BITWIDTH.
  - On rejection: shadow and pending are unchanged, and cfg_err pulses for one cycle on the cycle after cfg_load.
- frame_count increments by 1 on each wrap, modulo 2^FC_WIDTH.
- No cycle ever shows x >= H_MAX or y >= V_MAX of the active set.

Test Plan:
- Reset behaviour: rst with DEF_* = 640/16/96/48, 480/10/2/33, PIPE_DELAY = 0 -> hsync low exactly for x in 656..751; vsync low for y in 490..491; line period 800 clocks, frame period 525 lines; frame_count = 1 after 420000 clocks.
- Mode switch: load H 8/2/2/2, V 4/1/1/1, pol 1/1 mid-frame -> cfg_pending = 1 until the wrap; then H_MAX = 14, V_MAX = 7, hsync high only for x = 10..11, vsync high only at y = 5, frame period 98 clocks.
- Pipeline alignment: PIPE_DELAY = 3 -> every output equals the PIPE_DELAY = 0 output delayed by exactly 3 clocks; frame_start and x = 0, y = 0 coincide.
- Rejected load: cfg_load with cfg_h_res = 0 -> cfg_err pulses one cycle after the load; cfg_pending stays 0; timing unchanged.
- Load races:
  - Two loads (A, then B) before a wrap -> only B is applied.
  - A load that coincides with a wrap -> applied one frame later.
- Reset mid-pending: rst asserted while cfg_pending = 1 -> DEF_* timing resumes; cfg_pending = 0; frame_count = 0; x = y = 0.
